// File: rtl/pulse_delay_multi.sv
// Multi-channel programmable pulse delay / stretcher.
// Each channel waits a latched delay after a trigger rising edge, then drives a
// pulse of latched width. Channels also support retrigger, cancel, and sticky
// overrun flags. Channel state lives in pulse_delay_chan, one instance per channel.

module pulse_delay_chan #(
  parameter int CNT_W   = 8,
  parameter int PULSE_W = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               trig_i,
  input  logic [CNT_W-1:0]   delay_i,
  input  logic [PULSE_W-1:0] width_i,
  input  logic               retrig_i,
  input  logic               cancel_i,
  input  logic               ovr_clr_i,
  output logic               out_o,
  output logic               busy_o,
  output logic               overrun_o
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   dcnt_q;
  logic [PULSE_W-1:0] wcnt_q;
  logic               out_q;
  logic               ovr_q;
  logic               trig_q;
  logic               rise;
  logic [PULSE_W-1:0] wload;

  // History resets high so a trigger held through reset release cannot fire.
  assign rise  = trig_i & ~trig_q;
  // A zero width still produces a one-cycle pulse.
  assign wload = (width_i == '0) ? '0 : width_i - PULSE_W'(1);

  // Per-channel FSM: edge history, counters, registered pulse and overrun flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      wcnt_q  <= '0;
      out_q   <= 1'b0;
      ovr_q   <= 1'b0;
      trig_q  <= 1'b1;
    end else begin
      trig_q <= trig_i;
      // Clear first so a same-cycle drop below leaves the flag set.
      if (ovr_clr_i) ovr_q <= 1'b0;
      if (cancel_i) begin
        // Abort wins; a coincident trigger is discarded without flagging.
        state_q <= S_IDLE;
        out_q   <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (rise) begin
              state_q <= S_WAIT;
              dcnt_q  <= delay_i;
              wcnt_q  <= wload;
            end
          end
          S_WAIT: begin
            if (rise && retrig_i) begin
              // Restart timing from this edge with freshly sampled settings.
              dcnt_q <= delay_i;
              wcnt_q <= wload;
            end else begin
              if (rise) ovr_q <= 1'b1;
              if (dcnt_q == '0) begin
                state_q <= S_PULSE;
                out_q   <= 1'b1;
              end else begin
                dcnt_q <= dcnt_q - CNT_W'(1);
              end
            end
          end
          S_PULSE: begin
            if (rise) ovr_q <= 1'b1;
            if (wcnt_q == '0) begin
              state_q <= S_IDLE;
              out_q   <= 1'b0;
            end else begin
              wcnt_q <= wcnt_q - PULSE_W'(1);
            end
          end
          default: begin
            state_q <= S_IDLE;
            out_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_o     = out_q;
  assign busy_o    = (state_q != S_IDLE);
  assign overrun_o = ovr_q;
endmodule

module pulse_delay_multi #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int PULSE_W  = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [CHANNELS-1:0]         trig_i,
  input  logic [CHANNELS*CNT_W-1:0]   delay_i,
  input  logic [CHANNELS*PULSE_W-1:0] width_i,
  input  logic                        retrig_i,
  input  logic [CHANNELS-1:0]         cancel_i,
  input  logic                        ovr_clr_i,
  output logic [CHANNELS-1:0]         out_data_o,
  output logic [CHANNELS-1:0]         busy_o,
  output logic [CHANNELS-1:0]         overrun_o
);
  // One independent channel per trigger bit.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_delay_chan #(
      .CNT_W   (CNT_W),
      .PULSE_W (PULSE_W)
    ) u_ch (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .trig_i    (trig_i[g]),
      .delay_i   (delay_i[g*CNT_W +: CNT_W]),
      .width_i   (width_i[g*PULSE_W +: PULSE_W]),
      .retrig_i  (retrig_i),
      .cancel_i  (cancel_i[g]),
      .ovr_clr_i (ovr_clr_i),
      .out_o     (out_data_o[g]),
      .busy_o    (busy_o[g]),
      .overrun_o (overrun_o[g])
    );
  end
endmodule

// File: tb/tb_pulse_delay_multi.sv
// Bench for pulse_delay_multi: directed stimulus pushes expected pulses
// (start edge, width) per channel; a negedge monitor measures each pulse and
// pops/compares. Status outputs are checked directly by the stimulus thread.

module tb_pulse_delay_multi;
  localparam int CH = 2;
  localparam int CW = 8;
  localparam int PW = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [CH-1:0]    trig;
  logic [CH*CW-1:0] delay;
  logic [CH*PW-1:0] width;
  logic             retrig;
  logic [CH-1:0]    cancel;
  logic             ovr_clr;
  logic [CH-1:0]    out_data;
  logic [CH-1:0]    busy;
  logic [CH-1:0]    overrun;

  pulse_delay_multi #(.CHANNELS(CH), .CNT_W(CW), .PULSE_W(PW)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .trig_i     (trig),
    .delay_i    (delay),
    .width_i    (width),
    .retrig_i   (retrig),
    .cancel_i   (cancel),
    .ovr_clr_i  (ovr_clr),
    .out_data_o (out_data),
    .busy_o     (busy),
    .overrun_o  (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int start; int w; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int ch, input int start, input int w);
    exp_t e;
    e.start = start;
    e.w     = w;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Monitor: measure every pulse on each channel and compare with the queue.
  logic [CH-1:0] prev = '0;
  int            st[CH];
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (out_data[c] && !prev[c]) st[c] = cyc;
      if (!out_data[c] && prev[c]) begin
        exp_t e;
        int   qs;
        qs = (c == 0) ? q0.size() : q1.size();
        if (qs == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_pulse ch%0d: start %0d width %0d, none expected", c, st[c], cyc - st[c]);
        end else begin
          e = (c == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("pulse_start_ch%0d", c), st[c], e.start);
          chk($sformatf("pulse_width_ch%0d", c), cyc - st[c], e.w);
        end
      end
      prev[c] = out_data[c];
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Raise trig for one cycle with the given settings; k is the sampling edge.
  task automatic fire(input int ch, input int d, input int w, output int k);
    delay[ch*CW +: CW] = d[CW-1:0];
    width[ch*PW +: PW] = w[PW-1:0];
    trig[ch] = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    trig[ch] = 1'b0;
  endtask

  task automatic raise(input int ch);
    trig[ch] = 1'b1;
    @(negedge clk);
    trig[ch] = 1'b0;
  endtask

  task automatic clr_ovr();
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, k0, k1;
    reset = 1'b1; trig = '0; delay = '0; width = '0;
    retrig = 1'b0; cancel = '0; ovr_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic D=5 W=3; later input changes must not affect the pulse.
    fire(0, 5, 3, k);
    push_exp(0, k + 6, 3);
    delay[0 +: CW] = 8'd1;
    width[0 +: PW] = 4'd9;
    chk("t1_busy_start", busy[0], 1);
    wait_until(k + 8);
    chk("t1_busy_last", busy[0], 1);
    wait_until(k + 9);
    chk("t1_busy_end", busy[0], 0);
    chk("t1_out_end", out_data[0], 0);
    wait_until(k + 12);

    // Boundary widths/delays.
    fire(0, 0, 0, k);
    push_exp(0, k + 1, 1);
    wait_until(k + 5);
    fire(0, 255, 15, k);
    push_exp(0, k + 256, 15);
    wait_until(k + 255);
    chk("t2_busy_long", busy[0], 1);
    wait_until(k + 274);

    // retrig=0: drop during WAIT, clear, and coincident clear+drop.
    fire(0, 8, 2, k);
    push_exp(0, k + 9, 2);
    wait_until(k + 2);
    raise(0);
    chk("t3_ovr_set", overrun[0], 1);
    clr_ovr();
    chk("t3_ovr_clr", overrun[0], 0);
    trig[0] = 1'b1; ovr_clr = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0; ovr_clr = 1'b0;
    chk("t3_ovr_set_wins", overrun[0], 1);
    wait_until(k + 14);
    clr_ovr();

    // retrig=1: restart in WAIT, then drop during PULSE.
    retrig = 1'b1;
    fire(0, 10, 2, k);
    wait_until(k + 3);
    raise(0);
    push_exp(0, k + 15, 2);
    chk("t4_no_ovr", overrun[0], 0);
    wait_until(k + 15);
    raise(0);
    chk("t4_ovr_pulse", overrun[0], 1);
    wait_until(k + 20);
    clr_ovr();
    retrig = 1'b0;

    // Cancel mid-pulse on ch0 while ch1 runs.
    fire(1, 20, 6, k1);
    push_exp(1, k1 + 21, 6);
    fire(0, 2, 8, k0);
    push_exp(0, k0 + 3, 2);
    wait_until(k0 + 4);
    cancel[0] = 1'b1;
    @(negedge clk);
    cancel[0] = 1'b0;
    chk("t5_cancel_out", out_data[0], 0);
    chk("t5_cancel_busy", busy[0], 0);
    cancel[0] = 1'b1; trig[0] = 1'b1;
    @(negedge clk);
    cancel[0] = 1'b0; trig[0] = 1'b0;
    chk("t5_cancel_trig_busy", busy[0], 0);
    chk("t5_cancel_trig_ovr", overrun[0], 0);
    chk("t5_ch1_busy", busy[1], 1);
    wait_until(k1 + 30);

    // Async reset mid-WAIT with trig held across release.
    fire(0, 50, 2, k);
    wait_until(k + 3);
    raise(0);
    chk("t6_pre_busy", busy[0], 1);
    chk("t6_pre_ovr", overrun[0], 1);
    #2 reset = 1'b1;
    trig[0] = 1'b1;
    #1;
    chk("t6_rst_out", out_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovr", overrun, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_held_no_busy", busy[0], 0);
    trig[0] = 1'b0;
    @(negedge clk);
    fire(0, 1, 1, k);
    push_exp(0, k + 2, 1);
    wait_until(k + 6);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
